fifo_ram_ctrl: RTL
==================

// Module: fifo_ram_ctrl
// PURPOSE
// - Single-clock FIFO controller that sequences one external dual-port RAM (1-cycle registered read) as a FIFO.
// - Owns the write/read pointers, occupancy count and full/empty flags; drives the RAM address, data and write-enable ports.
// - The RAM's read and write clocks are both tied to clk.
// - Sits between a producer (push side) and a consumer (pop side, data returned one cycle after the pop).
// PARAMETERS
// - ADDR_BITS    8  RAM address width; FIFO depth DEPTH = 2**ADDR_BITS
// - WORD_LENGTH  8  data word width
// PORTS
// - clk         in   1              single clock; the RAM's w_clk and r_clk are tied to it
// - rst_n       in   1              asynchronous active-low reset
// - wr_en       in   1              push request
// - wr_data     in   WORD_LENGTH    push data
// - full        out  1              FIFO holds DEPTH words
// - rd_en       in   1              pop request
// - rd_data     out  WORD_LENGTH    popped word; valid only while rd_valid=1
// - rd_valid    out  1              rd_data carries the word popped on the previous cycle
// - empty       out  1              FIFO holds 0 words
// - count       out  ADDR_BITS+1    current occupancy, 0..DEPTH
// - ram_w_en    out  1              to RAM write enable
// - ram_w_addr  out  ADDR_BITS      to RAM write address
// - ram_w_data  out  WORD_LENGTH    to RAM write data
// - ram_r_addr  out  ADDR_BITS      to RAM read address
// - ram_r_data  in   WORD_LENGTH    from RAM registered read data
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, rd_valid=0.
//   - No RAM write occurs while in reset; rd_data is don't-care.
//   - Reset mid-operation discards all contents immediately.
// - Accept rules:
//   - push_ok = wr_en & ~full.
//   - pop_ok = rd_en & ~empty.
//   - full/empty are registered-state decodes: full = (count==DEPTH), empty = (count==0).
// - Write path (combinational):
//   - ram_w_en = push_ok, ram_w_addr = wr_ptr, ram_w_data = wr_data.
//   - wr_ptr increments on push_ok.
// - Read path:
//   - ram_r_addr = rd_ptr (combinational); rd_ptr increments on pop_ok.
//   - The RAM captures MEMORY[rd_ptr] on the pop edge.
//   - rd_valid is registered: rd_valid <= pop_ok.
//   - rd_data = ram_r_data (passthrough); latency from pop to data = 1 cycle.
// - Pointer wrap: DEPTH is a power of two, so pointers wrap DEPTH-1 -> 0 by natural ADDR_BITS overflow.
// - count update:
//   - push only: +1
//   - pop only: -1
//   - both or neither: unchanged
// - Simultaneous events:
//   - Full + push + pop: pop accepted, push rejected (ready does not look through a same-cycle pop); count becomes DEPTH-1.
//   - Empty + push + pop: push accepted, pop rejected; count becomes 1; rd_valid=0 next cycle.
//   - Push/pop are never refused while legal: no stalls, back-to-back push and pop at full rate.
// - Read-after-write: a word pushed at edge N is poppable from edge N+1; the RAM write at N completes before the read at N+1.
// - Illegal requests (push when full, pop when empty) are ignored: no pointer or count change, no RAM write.
// CONFIGURATION
// - FIFO_CTRL_ERR_FLAGS_EN defined:
//   - Adds ports: err_clr (in, 1), overflow (out, 1), underflow (out, 1).
//   - overflow sets on wr_en&full; underflow sets on rd_en&empty.
//   - Both flags are sticky until err_clr=1 for one cycle; a set in the same cycle as err_clr wins.
//   - Both reset to 0.
// - FIFO_CTRL_ERR_FLAGS_EN undefined: these ports and their logic do not exist; illegal requests are silently ignored.
// TESTING (ADDR_BITS=2, DEPTH=4, WORD_LENGTH=8; controller wired to a RAM_DUALPORT instance)
// - Reset, idle: count=0, empty=1, full=0, rd_valid=0, ram_w_en=0.
// - Push 0xA1..0xA4 back-to-back: full=1 after the 4th edge; 5th push 0xA5 gives ram_w_en=0, count stays 4.
// - Pop 4x back-to-back: rd_valid=1 on each following cycle with rd_data A1,A2,A3,A4; then empty=1.
// - Full + push + pop same cycle: count goes 4->3, popped data correct, pushed word dropped.
// - Empty + push 0x5C + pop same cycle: count=1, rd_valid=0; the next pop returns 0x5C.
// - Wrap: 10 interleaved push/pop pairs cross pointer 3->0 with data order preserved.
// - Assert rst_n=0 mid-stream with count=3: outputs return to reset values without a clock edge.
// - With FIFO_CTRL_ERR_FLAGS_EN: pop when empty -> underflow=1; it stays 1 until err_clr.

Source files
------------

// File: rtl/fifo_ram_ctrl.sv
// FIFO controller that sequences an external dual-port RAM (1-cycle registered read) as a FIFO.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_CTRL_ERR_FLAGS_EN.
module fifo_ram_ctrl #(
   parameter int ADDR_BITS   = 8,
   parameter int WORD_LENGTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [WORD_LENGTH-1:0] wr_data,
   output logic                   full,
   input  logic                   rd_en,
   output logic [WORD_LENGTH-1:0] rd_data,
   output logic                   rd_valid,
   output logic                   empty,
   output logic [ADDR_BITS:0]     count,
   output logic                   ram_w_en,
   output logic [ADDR_BITS-1:0]   ram_w_addr,
   output logic [WORD_LENGTH-1:0] ram_w_data,
   output logic [ADDR_BITS-1:0]   ram_r_addr,
   input  logic [WORD_LENGTH-1:0] ram_r_data
`ifdef FIFO_CTRL_ERR_FLAGS_EN
   ,
   input  logic                   err_clr,
   output logic                   overflow,
   output logic                   underflow
`endif
);

   localparam logic [ADDR_BITS:0] DEPTH_CNT = {1'b1, {ADDR_BITS{1'b0}}};

   logic [ADDR_BITS-1:0] wr_ptr;
   logic [ADDR_BITS-1:0] rd_ptr;
   logic                 push_ok;
   logic                 pop_ok;

   assign full  = (count == DEPTH_CNT);
   assign empty = (count == '0);

   // Push is qualified by rst_n so the RAM never sees a write while held in reset.
   assign push_ok = wr_en & ~full & rst_n;
   assign pop_ok  = rd_en & ~empty;

   assign ram_w_en   = push_ok;
   assign ram_w_addr = wr_ptr;
   assign ram_w_data = wr_data;
   assign ram_r_addr = rd_ptr;
   assign rd_data    = ram_r_data;

   // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= pop_ok;
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
   // A new error in the same cycle as err_clr keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (wr_en & full)  | (overflow  & ~err_clr);
         underflow <= (rd_en & empty) | (underflow & ~err_clr);
      end
   end
`endif

endmodule
